// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: parametrised, fully pipelined IEEE-style floating-point
// multiplier with valid/ready handshakes on both sides.
//
// Pipeline (PIPE_DEPTH stages, one register each):
//   stage 0            : unpack/classify operands, sign, biased exponent sum
//   stage 1            : (MAN_W+1)x(MAN_W+1) mantissa product
//   stages 2..D-2      : pure delay stages (only when PIPE_DEPTH > 3)
//   stage D-1 (output) : normalise, round, pack -> z/status registers
//
// Each stage advances when it is empty or its successor advances; the last
// stage advances on out_ready. Bubbles collapse and order is preserved.
//
// Optional macro FP_MULT_TAG_EN adds in_tag/out_tag; the tag rides along with
// its operation and appears on out_tag together with the result.
module fp_mult_pipe #(
    parameter int EXP_W      = 8,
    parameter int MAN_W      = 23,
    parameter int PIPE_DEPTH = 3,
    parameter int TAG_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic [2:0]           rnd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] z,
    output logic [7:0]           status
`ifdef FP_MULT_TAG_EN
    ,
    input  logic [TAG_W-1:0]     in_tag,
    output logic [TAG_W-1:0]     out_tag
`endif
);

    localparam int W  = EXP_W + MAN_W + 1;
    localparam int PW = 2 * MAN_W + 2;
    localparam int XW = EXP_W + 2;

    localparam logic [XW-1:0]    BIAS      = {3'b000, {(EXP_W-1){1'b1}}};
    localparam logic [XW-1:0]    EXP_LIMIT = {2'b00, {EXP_W{1'b1}}};
    localparam logic [XW-1:0]    EXP_ONE   = {{(XW-1){1'b0}}, 1'b1};
    localparam logic [EXP_W-1:0] EXP_ONES  = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EXP_MAXF  = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic [EXP_W-1:0] EXP_MINN  = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [EXP_W-1:0] EXP_ZERO  = {EXP_W{1'b0}};
    localparam logic [MAN_W-1:0] FRAC_ONES = {MAN_W{1'b1}};
    localparam logic [MAN_W-1:0] FRAC_ZERO = {MAN_W{1'b0}};
    localparam logic [W-1:0]     QNAN      = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    localparam logic [2:0] RND_NEAR    = 3'd0;
    localparam logic [2:0] RND_ZERO    = 3'd1;
    localparam logic [2:0] RND_PINF    = 3'd2;
    localparam logic [2:0] RND_NINF    = 3'd3;
    localparam logic [2:0] RND_NEAR_UP = 3'd4;
    localparam logic [2:0] RND_AWAY    = 3'd5;

    // Reject parameter sets the datapath slicing cannot support.
    if (EXP_W < 3 || MAN_W < 2 || PIPE_DEPTH < 3 || TAG_W < 1) begin : g_param_check
        $error("fp_mult_pipe: unsupported parameter set");
    end

    // Payload carried by the product stage and any delay stages.
    typedef struct packed {
        logic           sign;
        logic [XW-1:0]  exp;
        logic [PW-1:0]  prod;
        logic           nan;
        logic           inf;
        logic           zero;
        logic [2:0]     rnd;
`ifdef FP_MULT_TAG_EN
        logic [TAG_W-1:0] tag;
`endif
    } mid_t;

    // Decide whether the truncated mantissa is incremented.
    function automatic logic round_up(input logic [2:0] mode, input logic sgn,
                                      input logic lsb, input logic g, input logic s);
        logic r;
        case (mode)
            RND_ZERO:    r = 1'b0;
            RND_PINF:    r = !sgn && (g || s);
            RND_NINF:    r = sgn && (g || s);
            RND_NEAR_UP: r = g;
            RND_AWAY:    r = g || s;
            default:     r = g && (s || lsb);   // IEEE_near, also codes 6/7
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Handshake / stall chain
    // ------------------------------------------------------------------
    logic [PIPE_DEPTH-1:0] v_r;
    logic [PIPE_DEPTH-1:0] adv_s;
    logic                  chain_s;

    // Ripple the advance condition from the output back to stage 0.
    always_comb begin
        chain_s = !v_r[PIPE_DEPTH-1] || out_ready;
        adv_s   = {PIPE_DEPTH{1'b0}};
        adv_s[PIPE_DEPTH-1] = chain_s;
        for (int k = PIPE_DEPTH - 2; k >= 0; k--) begin
            chain_s  = !v_r[k] || chain_s;
            adv_s[k] = chain_s;
        end
    end

    assign in_ready  = adv_s[0] && !rst;
    assign out_valid = v_r[PIPE_DEPTH-1];

    // Stage valid bits: each stage takes its predecessor's valid on advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_r <= {PIPE_DEPTH{1'b0}};
        end else begin
            if (adv_s[0]) begin
                v_r[0] <= in_valid;
            end
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                if (adv_s[k]) begin
                    v_r[k] <= v_r[k-1];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 0: unpack and classify
    // ------------------------------------------------------------------
    logic [EXP_W-1:0] ea_s, eb_s;
    logic [MAN_W-1:0] fa_s, fb_s;
    logic             a_zero_s, a_inf_s, a_nan_s;
    logic             b_zero_s, b_inf_s, b_nan_s;
    logic             nan_s, inf_s, zero_s;
    logic [XW-1:0]    exp_sum_s;

    // Classify operands; subnormals are flushed to signed zero.
    always_comb begin
        ea_s      = a[W-2:MAN_W];
        eb_s      = b[W-2:MAN_W];
        fa_s      = a[MAN_W-1:0];
        fb_s      = b[MAN_W-1:0];
        a_zero_s  = (ea_s == EXP_ZERO);
        b_zero_s  = (eb_s == EXP_ZERO);
        a_inf_s   = (ea_s == EXP_ONES) && (fa_s == FRAC_ZERO);
        b_inf_s   = (eb_s == EXP_ONES) && (fb_s == FRAC_ZERO);
        a_nan_s   = (ea_s == EXP_ONES) && (fa_s != FRAC_ZERO);
        b_nan_s   = (eb_s == EXP_ONES) && (fb_s != FRAC_ZERO);
        nan_s     = a_nan_s || b_nan_s || (a_inf_s && b_zero_s) || (a_zero_s && b_inf_s);
        inf_s     = !nan_s && (a_inf_s || b_inf_s);
        zero_s    = !nan_s && !inf_s && (a_zero_s || b_zero_s);
        exp_sum_s = {2'b00, ea_s} + {2'b00, eb_s} - BIAS;
    end

    logic             s0_sign_r;
    logic [XW-1:0]    s0_exp_r;
    logic [MAN_W:0]   s0_ma_r, s0_mb_r;
    logic             s0_nan_r, s0_inf_r, s0_zero_r;
    logic [2:0]       s0_rnd_r;
`ifdef FP_MULT_TAG_EN
    logic [TAG_W-1:0] s0_tag_r;
`endif

    // Stage 0 register: capture classified operands on advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_sign_r <= 1'b0;
            s0_exp_r  <= {XW{1'b0}};
            s0_ma_r   <= {(MAN_W+1){1'b0}};
            s0_mb_r   <= {(MAN_W+1){1'b0}};
            s0_nan_r  <= 1'b0;
            s0_inf_r  <= 1'b0;
            s0_zero_r <= 1'b0;
            s0_rnd_r  <= 3'd0;
`ifdef FP_MULT_TAG_EN
            s0_tag_r  <= {TAG_W{1'b0}};
`endif
        end else if (adv_s[0]) begin
            s0_sign_r <= a[W-1] ^ b[W-1];
            s0_exp_r  <= exp_sum_s;
            s0_ma_r   <= {1'b1, fa_s};
            s0_mb_r   <= {1'b1, fb_s};
            s0_nan_r  <= nan_s;
            s0_inf_r  <= inf_s;
            s0_zero_r <= zero_s;
            s0_rnd_r  <= rnd;
`ifdef FP_MULT_TAG_EN
            s0_tag_r  <= in_tag;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: mantissa product, then optional delay stages
    // ------------------------------------------------------------------
    mid_t mid_in_s;
    mid_t mid_r [1:PIPE_DEPTH-2];

    // Form the full-width mantissa product and forward the stage 0 fields.
    always_comb begin
        mid_in_s.sign = s0_sign_r;
        mid_in_s.exp  = s0_exp_r;
        mid_in_s.prod = {{(MAN_W+1){1'b0}}, s0_ma_r} * {{(MAN_W+1){1'b0}}, s0_mb_r};
        mid_in_s.nan  = s0_nan_r;
        mid_in_s.inf  = s0_inf_r;
        mid_in_s.zero = s0_zero_r;
        mid_in_s.rnd  = s0_rnd_r;
`ifdef FP_MULT_TAG_EN
        mid_in_s.tag  = s0_tag_r;
`endif
    end

    // Product register followed by the pure delay stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= PIPE_DEPTH - 2; k++) begin
                mid_r[k] <= '0;
            end
        end else begin
            if (adv_s[1]) begin
                mid_r[1] <= mid_in_s;
            end
            for (int k = 2; k <= PIPE_DEPTH - 2; k++) begin
                if (adv_s[k]) begin
                    mid_r[k] <= mid_r[k-1];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output stage: normalise, round, pack
    // ------------------------------------------------------------------
    mid_t             fin_s;
    logic             msb_s, guard_s, sticky_s, up_s, inexact_s;
    logic [MAN_W:0]   mant_s;
    logic [MAN_W+1:0] man_sum_s;
    logic [MAN_W-1:0] frac_s;
    logic [XW-1:0]    exp_norm_s, exp_rnd_s;
    logic             ovf_s, unf_s, to_inf_s, to_min_s;
    logic [W-1:0]     res_z_s;
    logic [7:0]       res_status_s;

    // Normalise the product, round it and resolve special/over/underflow cases.
    always_comb begin
        fin_s = mid_r[PIPE_DEPTH-2];
        msb_s = fin_s.prod[PW-1];
        if (msb_s) begin
            mant_s   = fin_s.prod[PW-1:MAN_W+1];
            guard_s  = fin_s.prod[MAN_W];
            sticky_s = |fin_s.prod[MAN_W-1:0];
        end else begin
            mant_s   = fin_s.prod[PW-2:MAN_W];
            guard_s  = fin_s.prod[MAN_W-1];
            sticky_s = |fin_s.prod[MAN_W-2:0];
        end
        exp_norm_s = fin_s.exp + {{(XW-1){1'b0}}, msb_s};
        up_s       = round_up(fin_s.rnd, fin_s.sign, mant_s[0], guard_s, sticky_s);
        man_sum_s  = {1'b0, mant_s} + {{(MAN_W+1){1'b0}}, up_s};
        // A carry out of the mantissa leaves exactly 1.0, so the fraction is zero.
        exp_rnd_s  = exp_norm_s + {{(XW-1){1'b0}}, man_sum_s[MAN_W+1]};
        frac_s     = man_sum_s[MAN_W+1] ? man_sum_s[MAN_W:1] : man_sum_s[MAN_W-1:0];
        inexact_s  = guard_s || sticky_s;
        ovf_s      = $signed(exp_rnd_s) >= $signed(EXP_LIMIT);
        unf_s      = $signed(exp_rnd_s) < $signed(EXP_ONE);

        to_inf_s = 1'b1;
        case (fin_s.rnd)
            RND_ZERO: to_inf_s = 1'b0;
            RND_PINF: to_inf_s = !fin_s.sign;
            RND_NINF: to_inf_s = fin_s.sign;
            default:  to_inf_s = 1'b1;
        endcase

        to_min_s = 1'b0;
        case (fin_s.rnd)
            RND_AWAY: to_min_s = 1'b1;
            RND_PINF: to_min_s = !fin_s.sign;
            RND_NINF: to_min_s = fin_s.sign;
            default:  to_min_s = 1'b0;
        endcase

        res_z_s      = {fin_s.sign, exp_rnd_s[EXP_W-1:0], frac_s};
        res_status_s = {2'b00, inexact_s, 5'b00000};

        if (fin_s.nan) begin
            res_z_s      = QNAN;
            res_status_s = 8'h04;
        end else if (fin_s.inf) begin
            res_z_s      = {fin_s.sign, EXP_ONES, FRAC_ZERO};
            res_status_s = 8'h02;
        end else if (fin_s.zero) begin
            res_z_s      = {fin_s.sign, EXP_ZERO, FRAC_ZERO};
            res_status_s = 8'h01;
        end else if (ovf_s) begin
            if (to_inf_s) begin
                res_z_s      = {fin_s.sign, EXP_ONES, FRAC_ZERO};
                res_status_s = 8'h32;
            end else begin
                res_z_s      = {fin_s.sign, EXP_MAXF, FRAC_ONES};
                res_status_s = 8'h30;
            end
        end else if (unf_s) begin
            if (to_min_s) begin
                res_z_s      = {fin_s.sign, EXP_MINN, FRAC_ZERO};
                res_status_s = 8'h28;
            end else begin
                res_z_s      = {fin_s.sign, EXP_ZERO, FRAC_ZERO};
                res_status_s = 8'h29;
            end
        end else begin
            res_z_s      = {fin_s.sign, exp_rnd_s[EXP_W-1:0], frac_s};
            res_status_s = {2'b00, inexact_s, 5'b00000};
        end
    end

    logic [W-1:0]     z_r;
    logic [7:0]       status_r;
`ifdef FP_MULT_TAG_EN
    logic [TAG_W-1:0] out_tag_r;
`endif

    // Output register: load a new result only when a valid one moves in, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            z_r       <= {W{1'b0}};
            status_r  <= 8'h00;
`ifdef FP_MULT_TAG_EN
            out_tag_r <= {TAG_W{1'b0}};
`endif
        end else if (adv_s[PIPE_DEPTH-1] && v_r[PIPE_DEPTH-2]) begin
            z_r       <= res_z_s;
            status_r  <= res_status_s;
`ifdef FP_MULT_TAG_EN
            out_tag_r <= fin_s.tag;
`endif
        end
    end

    assign z      = z_r;
    assign status = status_r;
`ifdef FP_MULT_TAG_EN
    assign out_tag = out_tag_r;
`endif

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed self-checking bench for fp_mult_pipe (single precision, depth 3).
module tb_fp_mult_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rnd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] z;
    logic [7:0]  status;
`ifdef FP_MULT_TAG_EN
    logic [3:0]  in_tag;
    logic [3:0]  out_tag;
`endif

    int checks = 0;
    int errors = 0;

    fp_mult_pipe #(
        .EXP_W(8), .MAN_W(23), .PIPE_DEPTH(3), .TAG_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .rnd(rnd),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .z(z),
        .status(status)
`ifdef FP_MULT_TAG_EN
        ,
        .in_tag(in_tag),
        .out_tag(out_tag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One isolated operation with out_ready high: latency, result and status.
    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic [2:0] rm, input logic [31:0] ez, input logic [7:0] es);
        int n;
        a = av; b = bv; rnd = rm; in_valid = 1'b1; out_ready = 1'b1;
`ifdef FP_MULT_TAG_EN
        in_tag = av[3:0] ^ bv[7:4] ^ {1'b0, rm};
`endif
        #1;
        check($sformatf("%s.in_ready", tag), {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            step();
            n++;
        end
        check($sformatf("%s.latency", tag), n, 32'd3);
        check($sformatf("%s.z", tag), z, ez);
        check($sformatf("%s.status", tag), {24'd0, status}, {24'd0, es});
`ifdef FP_MULT_TAG_EN
        check($sformatf("%s.tag", tag), {28'd0, out_tag}, {28'd0, av[3:0] ^ bv[7:4] ^ {1'b0, rm}});
`endif
        step();
    endtask

    logic [31:0] ops_a [6];
    logic [31:0] ops_z [6];
    int          idx;
    int          rx;
    int          seen;
    logic        acc;
    logic        got;

    initial begin
        ops_a = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
        ops_z = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000, 32'h41200000, 32'h41400000};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = 32'h0; b = 32'h0; rnd = 3'd0;
`ifdef FP_MULT_TAG_EN
        in_tag = 4'h0;
`endif
        step();
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst.z", z, 32'h0);
        check("rst.status", {24'd0, status}, 32'd0);
        check("rst.in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst.in_ready", {31'd0, in_ready}, 32'd1);

        run_op("mul_1p5x2",   32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 8'h00);
        run_op("ulp_near",    32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 8'h20);
        run_op("ulp_pinf",    32'h3F800001, 32'h3F800001, 3'd2, 32'h3F800003, 8'h20);
        run_op("ulp_zero",    32'h3F800001, 32'h3F800001, 3'd1, 32'h3F800002, 8'h20);
        run_op("ovf_near",    32'h7F000000, 32'h7F000000, 3'd0, 32'h7F800000, 8'h32);
        run_op("ovf_zero",    32'h7F000000, 32'h7F000000, 3'd1, 32'h7F7FFFFF, 8'h30);
        run_op("ovf_neg_pinf",32'h7F000000, 32'hFF000000, 3'd2, 32'hFF7FFFFF, 8'h30);
        run_op("ovf_neg_ninf",32'h7F000000, 32'hFF000000, 3'd3, 32'hFF800000, 8'h32);
        run_op("inf_x_zero",  32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 8'h04);
        run_op("negzero_x2",  32'h80000000, 32'h40000000, 3'd0, 32'h80000000, 8'h01);
        run_op("nan_in",      32'h7FC00000, 32'h3F800000, 3'd0, 32'h7FC00000, 8'h04);
        run_op("inf_x_neg2",  32'h7F800000, 32'hC0000000, 3'd0, 32'hFF800000, 8'h02);
        run_op("unf_near",    32'h00800000, 32'h00800000, 3'd0, 32'h00000000, 8'h29);
        run_op("unf_away",    32'h00800000, 32'h00800000, 3'd5, 32'h00800000, 8'h28);
        run_op("unf_pos_ninf",32'h00800000, 32'h00800000, 3'd3, 32'h00000000, 8'h29);
        run_op("unf_neg_ninf",32'h80800000, 32'h00800000, 3'd3, 32'h80800000, 8'h28);
        run_op("unf_neg_pinf",32'h80800000, 32'h00800000, 3'd2, 32'h80000000, 8'h29);
        run_op("tie_even",    32'h3F800800, 32'h3F800800, 3'd0, 32'h3F801000, 8'h20);
        run_op("tie_near_up", 32'h3F800800, 32'h3F800800, 3'd4, 32'h3F801001, 8'h20);
        run_op("tie_odd",     32'h3F800800, 32'h3F801800, 3'd0, 32'h3F802002, 8'h20);
        run_op("sqrt2_near",  32'h3FB504F3, 32'h3FB504F3, 3'd0, 32'h3FFFFFFF, 8'h20);
        run_op("sqrt2_carry", 32'h3FB504F3, 32'h3FB504F3, 3'd2, 32'h40000000, 8'h20);
        run_op("rnd7_near",   32'h3F800800, 32'h3F801800, 3'd7, 32'h3F802002, 8'h20);
        run_op("subnormal",   32'h00400000, 32'h40000000, 3'd0, 32'h00000000, 8'h01);

        // Backpressure: six back-to-back offers with the consumer stalled.
        out_ready = 1'b0; b = 32'h40000000; rnd = 3'd0; idx = 0;
        for (int c = 0; c < 8; c++) begin
            a = ops_a[idx]; in_valid = 1'b1;
            #1;
            acc = in_ready;
            step();
            if (acc) idx++;
        end
        check("stall.accepts", idx, 32'd3);
        check("stall.in_ready", {31'd0, in_ready}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            check("stall.out_valid", {31'd0, out_valid}, 32'd1);
            check("stall.z_hold", z, ops_z[0]);
            step();
        end

        out_ready = 1'b1; rx = 0;
        for (int c = 0; c < 40 && rx < 6; c++) begin
            if (idx < 6) begin
                a = ops_a[idx]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            acc = in_valid && in_ready;
            got = out_valid;
            if (got && rx < 6) check($sformatf("drain.z%0d", rx), z, ops_z[rx]);
            step();
            if (acc) idx++;
            if (got) rx++;
        end
        in_valid = 1'b0;
        check("drain.count", rx, 32'd6);
        check("drain.issued", idx, 32'd6);
        check("drain.no_dup", {31'd0, out_valid}, 32'd0);

        // Reset with three operations in flight.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = ops_a[i]; in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst.out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst.z", z, 32'h0);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (out_valid) seen++;
        end
        check("midrst.no_stale", seen, 32'd0);
        run_op("after_rst", 32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_mult_pipe.md
Name: fp_mult_pipe

Overview:
Parametrised, fully pipelined floating-point multiplier with valid/ready handshakes on input and output. It generalises the registered single-precision multiply wrapper to any IEEE-style exponent/mantissa width and a configurable pipeline depth. It accepts one operation per cycle and applies backpressure without losing data. It sits between operand-issue logic and the result writeback/collection logic.

Parameters:
EXP_W, 8, exponent field width (>=3)
MAN_W, 23, stored fraction width (>=2)
PIPE_DEPTH, 3, stages from accept to out_valid (>=3); stages beyond 3 are pure delay stages inserted before the output stage
TAG_W, 4, sideband tag width (used only with FP_MULT_TAG_EN)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  operands present
in_ready  out  1  block can accept this cycle
a  in  EXP_W+MAN_W+1  operand A {sign,exp,frac}
b  in  EXP_W+MAN_W+1  operand B
rnd  in  3  rounding mode: 0 IEEE_near, 1 IEEE_zero, 2 IEEE_pinf, 3 IEEE_ninf, 4 near_up, 5 away_zero; 6/7 treated as IEEE_near
out_valid  out  1  result present
out_ready  in  1  consumer accepts
z  out  EXP_W+MAN_W+1  product
status  out  8  bit0 zero, bit1 inf, bit2 nan, bit3 tiny, bit4 huge, bit5 inexact, bits7:6 = 0
in_tag / out_tag  in/out  TAG_W  present only with FP_MULT_TAG_EN

Behaviour:
- Reset (rst=1 at clk edge): all stage valid bits cleared; out_valid=0, z=0, status=0, in_ready=0 during the reset cycle and 1 from the first cycle after reset. Reset asserted mid-operation discards all in-flight operations; no stale result appears afterwards.
- Transfer occurs when valid&&ready. Stage k advances when it is empty or stage k+1 advances; the last stage advances on out_ready or when empty. in_ready = !stage0_valid || stage0_advances (combinational from out_ready through the stall chain). Bubbles collapse. At most PIPE_DEPTH operations are in flight. Order is preserved.
- Latency: result visible on out_valid exactly PIPE_DEPTH cycles after acceptance with out_ready held high. Throughput is 1/cycle.
- out_valid/z/status/out_tag hold stable while out_valid && !out_ready.
- Stage 1: unpack, classify operands (zero, inf, NaN, normal). Subnormal inputs are treated as signed zero. Sign = sa^sb. Biased exponent sum uses EXP_W+2 bits signed: ea+eb-bias.
- Stage 2: (MAN_W+1)x(MAN_W+1) mantissa product, 2*MAN_W+2 bits.
- Final stage: normalise (shift 1 when product MSB set, exponent+1), guard bit plus sticky OR, round per rnd, renormalise on mantissa carry-out, pack.
- Special cases: NaN operand or inf*0 gives canonical qNaN (sign 0, exp all ones, frac MSB 1, rest 0), status nan only. inf*finite-nonzero gives signed inf, status inf. Zero operand gives signed zero, status zero.
- Overflow (exp >= all-ones): huge|inexact. IEEE_near/near_up/away_zero give signed inf (inf bit set). IEEE_zero gives signed max finite. IEEE_pinf gives +inf or -max. IEEE_ninf gives -inf or +max.
- Underflow (exp < 1 after rounding): tiny|inexact. IEEE_near/IEEE_zero/near_up give signed zero (zero bit set). away_zero gives signed min normal. IEEE_pinf gives +min normal if positive, else -0. IEEE_ninf gives -min normal if negative, else +0.
- inexact is set whenever guard|sticky is nonzero.

Optional Feature:
FP_MULT_TAG_EN. When defined, in_tag/out_tag ports exist and in_tag travels with its operation, appearing on out_tag with its result (out_tag reset to 0). When undefined, the ports and tag registers are absent; behaviour is otherwise identical.

Test Plan:
- Defaults, rnd=0: a=0x3FC00000, b=0x40000000 -> after 3 cycles z=0x40400000, status=0x00.
- a=b=0x3F800001: rnd=0 -> z=0x3F800002, status=0x20. rnd=2 -> z=0x3F800003. rnd=1 -> z=0x3F800002.
- a=b=0x7F000000: rnd=0 -> z=0x7F800000, status=0x32. rnd=1 -> z=0x7F7FFFFF, status=0x30.
- a=0x7F800000, b=0x00000000 -> z=0x7FC00000, status=0x04. a=0x80000000, b=0x40000000 -> z=0x80000000, status=0x01.
- Hold out_ready=0 while offering 6 back-to-back ops: in_ready drops after 3 accepts. Release out_ready: all 6 results emerge in order with no loss or duplication, and z is stable while stalled.
- Assert rst for 1 cycle with 3 ops in flight: out_valid=0 the following cycle and no old result appears. A new op issued afterwards returns after 3 cycles.
